// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared input-interface constants for the keypad front end and the input encoder.
// Key vector width and matrix geometry live here so both sides agree on layout.
package keypad_scan_ctrl_pkg;

  localparam int KEY_W     = 16;
  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int ROW_IDX_W = $clog2(ROWS);

  typedef logic [KEY_W-1:0] key_vec_t;

  // One-cold row drive pattern for the selected row index.
  function automatic logic [ROWS-1:0] row_drive(input logic [ROW_IDX_W-1:0] idx);
    row_drive = ~(ROWS'(1) << idx);
  endfunction

endpackage

// File: rtl/keypad_scan_ctrl_col_sync.sv
// Two-flop synchronizer bringing the asynchronous keypad columns into the clock domain.
// Idle columns read high, so both stages reset to all ones.
module col_sync
  import keypad_scan_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] col_async,
  output logic [COLS-1:0] col_o
);

  logic [COLS-1:0] meta_q, meta_d;
  logic [COLS-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = col_async;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign col_o = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Row-scanning keypad controller: drives one row at a time, samples the columns,
// and accepts a new key vector only after DEB_N identical complete scans.
module keypad_scan_ctrl
  import keypad_scan_ctrl_pkg::*;
#(
  parameter int SCAN_DIV = 8,
  parameter int DEB_N    = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic [COLS-1:0]  Col,
  output logic [ROWS-1:0]  Row,
  output logic [KEY_W-1:0] Key,
  output logic             Changed
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETTLE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE  = 2'd2;
  localparam logic [1:0] ST_COMPARE = 2'd3;

  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam int STAB_W = $clog2(DEB_N + 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0]    STAB_MAX = STAB_W'(DEB_N);
  localparam logic [ROW_IDX_W-1:0] ROW_LAST = ROW_IDX_W'(ROWS - 1);

  logic [1:0]           state_q, state_d;
  logic [ROW_IDX_W-1:0] r_q, r_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ROWS-1:0]      row_q, row_d;
  key_vec_t             raw_q, raw_d;
  key_vec_t             cand_q, cand_d;
  logic [STAB_W-1:0]    stab_q, stab_d;
  key_vec_t             key_q, key_d;
  logic                 changed_q, changed_d;
  logic [STAB_W-1:0]    stab_upd;
  logic [COLS-1:0]      col_s;

  col_sync u_col_sync (
    .clk       (Clock),
    .rst       (Reset),
    .col_async (Col),
    .col_o     (col_s)
  );

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    raw_d     = raw_q;
    cand_d    = cand_q;
    stab_d    = stab_q;
    key_d     = key_q;
    changed_d = 1'b0;
    stab_upd  = stab_q;

    // Dropping Enable parks the scanner and throws away the half-built scan.
    if (!Enable) begin
      state_d = ST_IDLE;
      r_d     = '0;
      cnt_d   = '0;
      raw_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          r_d     = '0;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            state_d = ST_SAMPLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SAMPLE: begin
          raw_d[int'(r_q)*COLS +: COLS] = ~col_s;
          if (r_q == ROW_LAST) begin
            state_d = ST_COMPARE;
          end else begin
            r_d     = r_q + ROW_IDX_W'(1);
            state_d = ST_SETTLE;
          end
        end
        default: begin
          if (raw_q != cand_q) begin
            cand_d   = raw_q;
            stab_upd = STAB_W'(1);
          end else if (stab_q < STAB_MAX) begin
            stab_upd = stab_q + STAB_W'(1);
          end
          stab_d = stab_upd;
          if ((stab_upd >= STAB_MAX) && (cand_d != key_q)) begin
            key_d     = cand_d;
            changed_d = 1'b1;
          end
          state_d = ST_SETTLE;
          r_d     = '0;
          cnt_d   = '0;
        end
      endcase
    end

    // Row is registered, so derive it from where the FSM is heading.
    row_d = ((state_d == ST_SETTLE) || (state_d == ST_SAMPLE)) ? row_drive(r_d) : '1;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      r_q       <= '0;
      cnt_q     <= '0;
      row_q     <= '1;
      raw_q     <= '0;
      cand_q    <= '0;
      stab_q    <= '0;
      key_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      raw_q     <= raw_d;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      key_q     <= key_d;
      changed_q <= changed_d;
    end
  end

  assign Row     = row_q;
  assign Key     = key_q;
  assign Changed = changed_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: a physical keypad model closes the loop
// and a scan-level behavioural model predicts Row, Key and Changed every cycle.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB_N    = 3;
  localparam int SLOT     = SCAN_DIV + 1;
  localparam int PERIOD   = 4 * SLOT + 1;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Enable;
  logic [3:0]  Col;
  logic [3:0]  Row;
  logic [15:0] Key;
  logic        Changed;

  logic [15:0] pressed = 16'h0000;

  int checks      = 0;
  int failures    = 0;
  int tick_pulses = 0;
  bit cmp_on      = 1'b0;

  // Behavioural model state: position inside the current scan (-1 when parked).
  int          m_t       = -1;
  logic [15:0] m_key     = 16'h0000;
  logic        m_changed = 1'b0;
  logic [15:0] m_scan    = 16'h0000;
  logic [15:0] hist[$];

  keypad_scan_ctrl #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_N    (DEB_N)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Enable  (Enable),
    .Col     (Col),
    .Row     (Row),
    .Key     (Key),
    .Changed (Changed)
  );

  always #5 Clock = ~Clock;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    Col = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if ((Row[r] === 1'b0) && pressed[4*r+c]) Col[c] = 1'b0;
  end

  // Scan-level model: a key vector is accepted once the last DEB_N complete
  // scans agree and differ from the current key.
  always @(posedge Clock) begin
    if (Reset) begin
      m_t = -1;
      m_key = 16'h0000;
      m_changed = 1'b0;
      m_scan = 16'h0000;
      hist.delete();
    end else if (!Enable) begin
      m_t = -1;
      m_changed = 1'b0;
      m_scan = 16'h0000;
    end else if (m_t < 0) begin
      m_t = 0;
      m_changed = 1'b0;
    end else begin
      bit all_same;
      m_changed = 1'b0;
      if ((m_t < 4*SLOT) && ((m_t % SLOT) == SLOT-1))
        m_scan[4*(m_t/SLOT) +: 4] = pressed[4*(m_t/SLOT) +: 4];
      if (m_t == PERIOD-1) begin
        hist.push_back(m_scan);
        if (hist.size() > DEB_N) void'(hist.pop_front());
        all_same = (hist.size() == DEB_N);
        foreach (hist[i]) if (hist[i] != hist[0]) all_same = 1'b0;
        if (all_same && (hist[0] != m_key)) begin
          m_key = hist[0];
          m_changed = 1'b1;
        end
      end
      m_t = (m_t + 1) % PERIOD;
    end
  end

  function automatic logic [3:0] exp_row();
    logic [3:0] one = 4'b0001;
    if ((m_t >= 0) && (m_t < 4*SLOT)) return ~(one << (m_t / SLOT));
    return 4'b1111;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [15:0] prs);
    Reset   = rst;
    Enable  = en;
    pressed = prs;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clock);
      if (Changed === 1'b1) tick_pulses++;
    end
  endtask

  task automatic waitPhase(input int target);
    bit found = 1'b0;
    for (int i = 0; i < 4*PERIOD; i++) begin
      tick(1);
      if (m_t == target) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("[TB] FAIL wait_phase: phase %0d not reached, got %0d", target, m_t);
    end
  endtask

  always @(negedge Clock) begin
    if (cmp_on) begin
      checkOutput("model_row", 32'(Row), 32'(exp_row()));
      checkOutput("model_key", 32'(Key), 32'(m_key));
      checkOutput("model_changed", 32'(Changed), 32'(m_changed));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 16'h0000);
    @(posedge Clock);
    #1 cmp_on = 1'b1;
    tick(3);
    checkOutput("reset_row", 32'(Row), 32'h0000_000F);
    checkOutput("reset_key", 32'(Key), 32'h0000_0000);
    checkOutput("reset_changed", 32'(Changed), 32'h0);

    // Single press at row 3, column 2, present from the very first scan.
    $display("[TB] single press and first scan timing");
    applyStimulus(1'b0, 1'b1, 16'h4000);
    tick_pulses = 0;
    for (int i = 0; i < SLOT; i++) begin
      tick(1);
      checkOutput("row0_drive", 32'(Row), 32'h0000_000E);
    end
    tick(1);
    checkOutput("row1_drive", 32'(Row), 32'h0000_000D);
    tick(3*PERIOD - SLOT - 1);
    checkOutput("key_before_accept", 32'(Key), 32'h0000_0000);
    tick(1);
    checkOutput("key_accept_4000", 32'(Key), 32'h0000_4000);
    checkOutput("changed_accept_4000", 32'(Changed), 32'h1);
    checkOutput("pulses_accept_4000", 32'(tick_pulses), 32'd1);
    tick_pulses = 0;
    tick(3*PERIOD);
    checkOutput("no_extra_pulses", 32'(tick_pulses), 32'd0);
    checkOutput("key_held_4000", 32'(Key), 32'h0000_4000);

    // Add a second key, then release the first.
    $display("[TB] add and release keys");
    waitPhase(PERIOD-1);
    applyStimulus(1'b0, 1'b1, 16'h4400);
    tick_pulses = 0;
    tick(3*PERIOD);
    checkOutput("key_before_4400", 32'(Key), 32'h0000_4000);
    tick(1);
    checkOutput("key_4400", 32'(Key), 32'h0000_4400);
    checkOutput("pulses_4400", 32'(tick_pulses), 32'd1);
    waitPhase(PERIOD-1);
    applyStimulus(1'b0, 1'b1, 16'h0400);
    tick_pulses = 0;
    tick(3*PERIOD);
    checkOutput("key_before_0400", 32'(Key), 32'h0000_4400);
    tick(1);
    checkOutput("key_0400", 32'(Key), 32'h0000_0400);
    checkOutput("pulses_0400", 32'(tick_pulses), 32'd1);

    // Drop Enable while row 2 is settling, then resume.
    $display("[TB] enable drop and restart");
    waitPhase(2*SLOT + 1);
    applyStimulus(1'b0, 1'b0, 16'h0400);
    tick(1);
    checkOutput("parked_row", 32'(Row), 32'h0000_000F);
    checkOutput("parked_key", 32'(Key), 32'h0000_0400);
    tick(3);
    checkOutput("parked_row_hold", 32'(Row), 32'h0000_000F);
    applyStimulus(1'b0, 1'b1, 16'h0400);
    tick(1);
    checkOutput("restart_row0", 32'(Row), 32'h0000_000E);
    tick_pulses = 0;
    tick(DEB_N*PERIOD);
    checkOutput("restart_pulses", 32'(tick_pulses), 32'd0);
    checkOutput("restart_key", 32'(Key), 32'h0000_0400);

    // Bouncing press: toggles every scan, never stable long enough.
    $display("[TB] bouncing press");
    applyStimulus(1'b1, 1'b1, 16'h0000);
    tick(3);
    checkOutput("reset2_key", 32'(Key), 32'h0000_0000);
    applyStimulus(1'b0, 1'b1, 16'h4000);
    tick_pulses = 0;
    for (int s = 0; s < 10; s++) begin
      waitPhase(PERIOD-1);
      pressed = pressed ^ 16'h4000;
    end
    checkOutput("bounce_key", 32'(Key), 32'h0000_0000);
    checkOutput("bounce_pulses", 32'(tick_pulses), 32'd0);

    // Reset one cycle before the accepting compare.
    $display("[TB] reset before accept");
    applyStimulus(1'b1, 1'b1, 16'h0000);
    tick(3);
    applyStimulus(1'b0, 1'b1, 16'h4000);
    tick(3*PERIOD - 2);
    checkOutput("row3_before_reset", 32'(Row), 32'h0000_0007);
    applyStimulus(1'b1, 1'b1, 16'h4000);
    tick(1);
    checkOutput("late_reset_key", 32'(Key), 32'h0000_0000);
    checkOutput("late_reset_changed", 32'(Changed), 32'h0);
    checkOutput("late_reset_row", 32'(Row), 32'h0000_000F);
    applyStimulus(1'b0, 1'b1, 16'h4000);
    tick_pulses = 0;
    tick(3*PERIOD);
    checkOutput("fresh_before_accept", 32'(Key), 32'h0000_0000);
    tick(1);
    checkOutput("fresh_accept", 32'(Key), 32'h0000_4000);
    checkOutput("fresh_pulses", 32'(tick_pulses), 32'd1);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
